// File: rtl/sparse_mac_lane.sv
// sparse_mac_lane
//   Consumes {val, col, row} triplets from one fetcher channel (three
//   non-FWFT lanes read in lock-step), multiplies val by x[col] from a local
//   256x8 vector RAM and accumulates per row. Each row's sum is pushed into a
//   small valid/ready result queue. Row 8'hFF ends the stream.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   start / done        begin a stream (from IDLE or DONE) / stream finished
//   fifo_dout           [7:0] val (signed), [15:8] col, [23:16] row
//   fifo_empty          empty flags of the val/col/row lanes
//   fifo_read           read enables of the three lanes (all-ones or all-zeros)
//   x_we/x_addr/x_data  vector RAM write port
//   y_valid/y_ready     result queue handshake
//   y_row/y_data        head of the result queue (row index, ACC_W-bit sum)
module sparse_mac_lane #(
    parameter int ACC_W     = 24,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    input  logic [23:0]      fifo_dout,
    input  logic [2:0]       fifo_empty,
    output logic [2:0]       fifo_read,
    input  logic             x_we,
    input  logic [7:0]       x_addr,
    input  logic [7:0]       x_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [7:0]       y_row,
    output logic [ACC_W-1:0] y_data
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = PTR_W + 2;   // holds queue count + up to 3 in flight

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] SENTINEL = 8'hFF;

    // Control and pipeline state.
    logic [1:0]              state_q, state_d;
    logic                    stop_issue_q, stop_issue_d;
    logic                    p1_valid_q, p1_valid_d;   // fifo_dout valid this cycle
    logic                    d_valid_q, d_valid_d;
    logic [7:0]              d_row_q, d_row_d;
    logic [7:0]              d_val_q, d_val_d;
    logic [7:0]              x_rd_q, x_rd_d;
    logic                    m_valid_q, m_valid_d;
    logic [7:0]              m_row_q, m_row_d;
    logic signed [15:0]      m_prod_q, m_prod_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [7:0]              cur_row_q, cur_row_d;
    logic                    have_row_q, have_row_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        q_count_q, q_count_d;

    // Storage.
    logic [7:0]              x_mem      [256];
    logic [7:0]              q_row_mem  [OUT_DEPTH];
    logic [ACC_W-1:0]        q_data_mem [OUT_DEPTH];

    logic [1:0]              inflight;
    logic [OCC_W-1:0]        occupancy;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [ACC_W-1:0]        prod_ext;
    logic signed [15:0]      val_ext;
    logic signed [15:0]      x_ext;

    // Issue only when every entry in flight is guaranteed a queue slot, so
    // the pipeline never has to stall.
    always_comb begin
        inflight  = 2'(p1_valid_q) + 2'(d_valid_q) + 2'(m_valid_q);
        occupancy = OCC_W'(q_count_q) + OCC_W'(inflight);
        issue     = (state_q == ST_RUN) && !(|fifo_empty) && !stop_issue_q
                    && (occupancy < OCC_W'(OUT_DEPTH));
    end

    assign fifo_read = {3{issue}};
    assign done      = (state_q == ST_DONE);

    // Capture (D) and multiply (M) stages. The RAM is addressed straight from
    // fifo_dout so its data lines up with the captured val one cycle later.
    always_comb begin
        p1_valid_d = issue;
        d_valid_d  = p1_valid_q;
        d_row_d    = fifo_dout[23:16];
        d_val_d    = fifo_dout[7:0];
        x_rd_d     = x_mem[fifo_dout[15:8]];
        val_ext    = {{8{d_val_q[7]}}, d_val_q};
        x_ext      = {{8{x_rd_q[7]}}, x_rd_q};
        m_valid_d  = d_valid_q;
        m_row_d    = d_row_q;
        m_prod_d   = val_ext * x_ext;
    end

    // Accumulate (A) stage, FSM and result-queue bookkeeping.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d      = state_q;
        stop_issue_d = stop_issue_q;
        acc_d        = acc_q;
        cur_row_d    = cur_row_q;
        have_row_d   = have_row_q;
        push         = 1'b0;
        prod_ext     = ACC_W'(m_prod_q);

        if (p1_valid_q && fifo_dout[23:16] == SENTINEL) begin
            stop_issue_d = 1'b1;
        end

        // Entries trailing a sentinel reach A after the state has left RUN
        // and are dropped.
        if (m_valid_q && state_q == ST_RUN) begin
            if (m_row_q == SENTINEL) begin
                push    = have_row_q;
                state_d = ST_DONE;
            end else if (!have_row_q) begin
                acc_d      = prod_ext;
                cur_row_d  = m_row_q;
                have_row_d = 1'b1;
            end else if (m_row_q == cur_row_q) begin
                acc_d = acc_q + prod_ext;
            end else begin
                push      = 1'b1;
                acc_d     = prod_ext;
                cur_row_d = m_row_q;
            end
        end

        if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d      = ST_RUN;
            stop_issue_d = 1'b0;
            acc_d        = '0;
            have_row_d   = 1'b0;
        end
    end

    assign y_valid = (q_count_q != '0);
    assign pop     = y_valid && y_ready;
    // Gated so the outputs read zero while the queue is empty (including
    // straight after reset, when the unreset storage holds junk).
    assign y_row   = y_valid ? q_row_mem[rd_ptr_q]  : '0;
    assign y_data  = y_valid ? q_data_mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        q_count_d = q_count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            stop_issue_q <= 1'b0;
            p1_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            d_row_q      <= '0;
            d_val_q      <= '0;
            x_rd_q       <= '0;
            m_valid_q    <= 1'b0;
            m_row_q      <= '0;
            m_prod_q     <= '0;
            acc_q        <= '0;
            cur_row_q    <= '0;
            have_row_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            q_count_q    <= '0;
        end else begin
            state_q      <= state_d;
            stop_issue_q <= stop_issue_d;
            p1_valid_q   <= p1_valid_d;
            d_valid_q    <= d_valid_d;
            d_row_q      <= d_row_d;
            d_val_q      <= d_val_d;
            x_rd_q       <= x_rd_d;
            m_valid_q    <= m_valid_d;
            m_row_q      <= m_row_d;
            m_prod_q     <= m_prod_d;
            acc_q        <= acc_d;
            cur_row_q    <= cur_row_d;
            have_row_q   <= have_row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            q_count_q    <= q_count_d;
        end
    end

    // NOTE: memories are deliberately left out of reset; the vector RAM must
    // survive reset and queue slots are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_mem[x_addr] <= x_data;
        end
        if (push) begin
            q_row_mem[wr_ptr_q]  <= cur_row_q;
            q_data_mem[wr_ptr_q] <= acc_q;
        end
    end

endmodule

// File: tb/tb_sparse_mac_lane.sv
// tb_sparse_mac_lane
//   Drives sparse_mac_lane (ACC_W=24) and a twin with ACC_W=16 on identical
//   inputs from a behavioural fetcher FIFO and checks results against a
//   scoreboard: directed sequences, a table of single-row vectors and random
//   streams scored by a row-grouping reference model.
module tb_sparse_mac_lane;

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] val;
    } trip_t;

    typedef struct {
        logic [7:0]  row;
        logic [23:0] data;
        logic [15:0] d16;
    } res_t;

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  val;
        logic [7:0]  xv;
        int          n;
        logic [23:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done, done16;
    logic [23:0] fifo_dout;
    logic [2:0]  fifo_empty;
    logic [2:0]  fifo_read, fifo_read16;
    logic        x_we;
    logic [7:0]  x_addr;
    logic [7:0]  x_data;
    logic        y_valid, y_valid16;
    logic        y_ready;
    logic [7:0]  y_row, y_row16;
    logic [23:0] y_data;
    logic [15:0] y_data16;

    always #5 clk = ~clk;

    sparse_mac_lane #(.ACC_W(24), .OUT_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_data(y_data)
    );

    sparse_mac_lane #(.ACC_W(16), .OUT_DEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .done(done16),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_read(fifo_read16),
        .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
        .y_valid(y_valid16), .y_ready(y_ready), .y_row(y_row16), .y_data(y_data16)
    );

    trip_t      fq[$];
    res_t       exp_q[$];
    logic [7:0] x_model [256];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] empty_mask = 3'b000;
    bit         rand_ready = 1'b0;
    bit         rand_stall = 1'b0;

    logic [2:0]  s_rd;
    logic        s_done, s_yv;
    logic [7:0]  s_row;
    logic [23:0] s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic update_empty();
        fifo_empty = ((fq.size() == 0) ? 3'b111 : 3'b000) | empty_mask;
    endtask

    // One clock cycle: sample outputs on the falling edge, score any result
    // handshake, then after the rising edge play the fetcher FIFO.
    task automatic step();
        res_t  e;
        trip_t t;
        @(negedge clk);
        s_rd   = fifo_read;
        s_done = done;
        s_yv   = y_valid;
        s_row  = y_row;
        s_data = y_data;
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got row %0h data %0h, expected none", y_row, y_data);
            end else begin
                e = exp_q.pop_front();
                check("result_row", y_row, e.row);
                check("result_data", y_data, e.data);
                check("result_data16", y_data16, e.d16);
            end
        end
        @(posedge clk);
        #1;
        if (s_rd[0] && fq.size() > 0) begin
            t = fq.pop_front();
            fifo_dout = {t.row, t.col, t.val};
        end
        if (rand_ready) y_ready = ($urandom_range(0, 9) < 7);
        if (rand_stall) empty_mask = ($urandom_range(0, 4) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
        update_empty();
    endtask

    task automatic load_x(input logic [7:0] a, input logic [7:0] d);
        x_addr = a;
        x_data = d;
        x_we   = 1'b1;
        step();
        x_we   = 1'b0;
        x_model[a] = d;
    endtask

    task automatic push_trip(input logic [7:0] row, input logic [7:0] col, input logic [7:0] val);
        trip_t t;
        t.row = row;
        t.col = col;
        t.val = val;
        fq.push_back(t);
    endtask

    task automatic push_exp(input logic [7:0] row, input logic [23:0] data, input logic [15:0] d16);
        res_t r;
        r.row  = row;
        r.data = data;
        r.d16  = d16;
        exp_q.push_back(r);
    endtask

    task automatic pulse_start();
        update_empty();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait for DONE with everything consumed, then confirm reads have stopped.
    task automatic wait_done(input string name, input int budget);
        int n = 0;
        step();
        while (!(s_done && fq.size() == 0 && exp_q.size() == 0 && !s_yv) && n < budget) begin
            step();
            n++;
        end
        check({name, "_finished"}, (n < budget), 1'b1);
        check({name, "_pending_results"}, exp_q.size(), 0);
        step();
        check({name, "_done"}, s_done, 1'b1);
        check({name, "_read_after_done"}, s_rd, 3'b000);
    endtask

    // Reference: group consecutive entries with equal row, sum the products
    // as integers, emit one result per group, stop at the sentinel.
    task automatic model_stream(input trip_t s[$]);
        int         sum = 0;
        logic [7:0] cur = 8'h00;
        bit         have = 1'b0;
        foreach (s[i]) begin
            if (s[i].row == 8'hFF) break;
            if (have && s[i].row != cur) begin
                push_exp(cur, 24'(sum), 16'(sum));
                sum = 0;
            end
            cur  = s[i].row;
            have = 1'b1;
            sum += int'($signed(s[i].val)) * int'($signed(x_model[s[i].col]));
        end
        if (have) push_exp(cur, 24'(sum), 16'(sum));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt [6];
        trip_t rs[$];
        int    reads;
        bit    seen;
        bit    found;

        vt[0] = '{8'd3,   8'd2,   8'd3,   2, 24'd12};
        vt[1] = '{8'd5,   8'hFF,  8'd1,   1, 24'hFFFFFF};
        vt[2] = '{8'd9,   8'h80,  8'h80,  3, 24'h00C000};
        vt[3] = '{8'd0,   8'd127, 8'h80,  1, 24'hFFC080};
        vt[4] = '{8'd200, 8'd0,   8'd55,  2, 24'h000000};
        vt[5] = '{8'd254, 8'h80,  8'd127, 4, 24'hFF0200};

        rst = 1'b0; start = 1'b0; x_we = 1'b0; x_addr = '0; x_data = '0;
        y_ready = 1'b1; fifo_dout = '0;
        update_empty();
        step();
        step();
        rst = 1'b1;
        step();
        check("reset_y_valid", s_yv, 1'b0);
        check("reset_y_row", s_row, 8'h00);
        check("reset_y_data", s_data, 24'h0);
        check("reset_done", s_done, 1'b0);
        check("reset_fifo_read", s_rd, 3'b000);

        // Basic MAC.
        for (int i = 0; i < 8; i++) load_x(8'(i), 8'(i + 1));
        push_trip(8'd0, 8'd0, 8'd2);
        push_trip(8'd0, 8'd1, 8'd3);
        push_trip(8'd1, 8'd2, 8'hFF);
        push_trip(8'hFF, 8'd0, 8'd0);
        push_exp(8'd0, 24'd8, 16'd8);
        push_exp(8'd1, 24'hFFFFFD, 16'hFFFD);
        pulse_start();
        wait_done("basic", 200);

        // Backpressure: queue fills, issue stops at 5 reads, head holds.
        load_x(8'd10, 8'd1);
        y_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_trip(8'(i), 8'd10, 8'd1);
            push_exp(8'(i), 24'd1, 16'd1);
        end
        push_trip(8'hFF, 8'd0, 8'd0);
        pulse_start();
        reads = 0;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (s_rd[0]) reads++;
            if (seen) check("bp_head_hold", {s_yv, s_row, s_data}, {1'b1, 8'd0, 24'd1});
            if (s_yv) seen = 1'b1;
        end
        check("bp_reads_while_stalled", reads, 5);
        y_ready = 1'b1;
        wait_done("backpressure", 200);

        // Empty gating: one lane empty blocks issue until cleared.
        push_trip(8'd2, 8'd3, 8'd5);
        push_trip(8'hFF, 8'd0, 8'd0);
        push_exp(8'd2, 24'd20, 16'd20);
        empty_mask = 3'b010;
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            step();
            check("gate_no_read", s_rd, 3'b000);
            check("gate_no_done", s_done, 1'b0);
        end
        empty_mask = 3'b000;
        update_empty();
        step();
        check("gate_resume_read", s_rd, 3'b111);
        wait_done("gating", 200);

        // Wrap: 3 * 127 * 127 = 0xBD03, overflows a 16-bit accumulator's sign.
        load_x(8'd7, 8'd127);
        for (int i = 0; i < 3; i++) push_trip(8'd7, 8'd7, 8'd127);
        push_trip(8'hFF, 8'd0, 8'd0);
        push_exp(8'd7, 24'h00BD03, 16'hBD03);
        pulse_start();
        wait_done("wrap", 200);

        // Sentinel only: no result, done three edges after the issue edge.
        push_trip(8'hFF, 8'd0, 8'd0);
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (s_rd[0]) found = 1'b1;
        end
        check("sent_issued", found, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("sent_done_early", s_done, 1'b0);
        end
        step();
        check("sent_done", s_done, 1'b1);
        check("sent_no_result", s_yv, 1'b0);

        // Table-driven single-row vectors.
        for (int i = 0; i < 6; i++) begin
            load_x(8'(100 + i), vt[i].xv);
            for (int k = 0; k < vt[i].n; k++) push_trip(vt[i].row, 8'(100 + i), vt[i].val);
            push_trip(8'hFF, 8'd0, 8'd0);
            push_exp(vt[i].row, vt[i].exp, vt[i].exp[15:0]);
            pulse_start();
            wait_done("table", 200);
        end

        // Reset mid-stream with results queued and entries in flight.
        y_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_trip(8'(20 + i), 8'd10, 8'd1);
        push_trip(8'hFF, 8'd0, 8'd0);
        pulse_start();
        for (int c = 0; c < 7; c++) step();
        check("pre_reset_queued", s_yv, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        fq.delete();
        exp_q.delete();
        push_trip(8'd40, 8'd10, 8'd3);
        push_trip(8'd41, 8'd10, 8'd3);
        push_trip(8'hFF, 8'd0, 8'd0);
        update_empty();
        step();
        check("mid_reset_y_valid", s_yv, 1'b0);
        check("mid_reset_read", s_rd, 3'b000);
        check("mid_reset_done", s_done, 1'b0);
        check("mid_reset_y_data", s_data, 24'h0);
        step();
        check("idle_no_issue", s_rd, 3'b000);
        y_ready = 1'b1;
        push_exp(8'd40, 24'd3, 16'd3);
        push_exp(8'd41, 24'd3, 16'd3);
        pulse_start();
        wait_done("after_reset", 200);

        // Random streams with random backpressure and empty stalls.
        for (int a = 0; a < 256; a++) load_x(8'(a), 8'($urandom));
        rand_ready = 1'b1;
        rand_stall = 1'b1;
        for (int s = 0; s < 8; s++) begin
            trip_t t;
            rs.delete();
            for (int k = 0; k < int'($urandom_range(1, 20)); k++) begin
                t.row = 8'($urandom_range(0, 4));
                t.col = 8'($urandom);
                t.val = 8'($urandom);
                rs.push_back(t);
            end
            t.row = 8'hFF;
            t.col = 8'd0;
            t.val = 8'd0;
            rs.push_back(t);
            model_stream(rs);
            foreach (rs[i]) fq.push_back(rs[i]);
            pulse_start();
            wait_done("random", 2000);
        end
        rand_ready = 1'b0;
        rand_stall = 1'b0;
        empty_mask = 3'b000;
        y_ready    = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sparse_mac_lane.md
Name: sparse_mac_lane

Overview:
- Downstream consumer of one channel of `fetcher`.
- Pops {val, col, row} triplets from that channel's three fetcher FIFOs and looks up `x[col]` in a local 256x8 vector RAM.
- Multiply-accumulates per row and emits one (row, sum) result per row through a valid/ready output queue.
- A row value of 8'hFF is the end-of-stream sentinel.

Parameters:
- ACC_W, 24, accumulator and result width (two's complement, wraps modulo 2^ACC_W).
- OUT_DEPTH, 4, result queue depth; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a stream. Ignored unless state is IDLE or DONE.
- done  out  1  high in DONE state.
- fifo_dout  in  24  fetcher channel out: [7:0]=val (signed), [15:8]=col, [23:16]=row.
- fifo_empty  in  3  fetcher empty flags for the val/col/row lanes.
- fifo_read  out  3  rd_en to the three lanes; always driven as all-ones or all-zeros.
- x_we  in  1  vector RAM write enable.
- x_addr  in  8  vector RAM write address.
- x_data  in  8  vector element, signed.
- y_valid  out  1  result queue head valid.
- y_ready  in  1  consumer accepts head.
- y_row  out  8  row index of head.
- y_data  out  ACC_W  row sum of head.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; fifo_read=0; done=0; y_valid=0; y_row=0; y_data=0.
  - Queue emptied; in-flight count=0; acc=0; have_row=0.
  - Vector RAM contents are not reset.
  - A reset mid-stream discards in-flight entries and queued results.
- States:
  - IDLE -start-> RUN.
  - RUN -sentinel reaches A stage-> DONE.
  - DONE -start-> RUN.
  - start clears acc and have_row.
- FIFO handshake (non-FWFT):
  - issue = (state==RUN) & ~|fifo_empty & ~stop_issue & (q_count + inflight < OUT_DEPTH).
  - fifo_read={3{issue}}.
  - fifo_dout is valid the cycle after issue and is always captured; the pipeline never stalls.
  - stop_issue sets when a captured row==8'hFF; it clears on start or reset.
- Pipeline (issue in cycle t):
  - t+1: capture triplet (stage D); drive RAM read address = col.
  - t+2: RAM data; product = sext16(val)*sext16(x[col]) registered (stage M).
  - t+3: accumulate stage A.
- inflight counts entries in D/M/A, range 0..3. Each entry produces at most one result, so the queue can never overflow.
- Stage A rules:
  - row==8'hFF: if have_row, push (cur_row, acc); state->DONE; the product is ignored.
  - ~have_row: acc=sext(product); cur_row=row; have_row=1.
  - row==cur_row: acc=acc+sext(product), wrapping.
  - row!=cur_row: push (cur_row, acc); acc=sext(product); cur_row=row.
- Result queue:
  - FIFO ordered; head drives y_*; a pop occurs on y_valid&y_ready.
  - A push and a pop in the same cycle are both honoured.
  - y_row/y_data hold their value while y_valid&~y_ready.
  - A result pushed at the end of cycle t+3 is visible at cycle t+4 if the queue was empty.
- Vector RAM: write (x_we) takes effect at the next edge. A same-cycle read of the same address returns old data. Loading during RUN is permitted but its result is unspecified for in-flight entries.
- Rows need not be sorted. Non-contiguous repeats of a row produce separate results.

Test Plan:
- Basic MAC:
  - Stimulus: load x[i]=i+1 for i=0..7; stream (r0,c0,v2),(r0,c1,v3),(r1,c2,v-1),(r=FF), y_ready=1.
  - Required: results (0, 24'd8) then (1, 24'hFFFFFD); done=1; fifo_read low after the sentinel.
- Backpressure:
  - Stimulus: y_ready=0; 6 single-entry rows r0..r5, each with val=1 and x=1, then FF.
  - Required: y_valid stays high holding (0,1); fifo_read ceases once queue plus inflight reaches 4.
  - Then y_ready=1: results r0..r5 (each 1) appear in order; nothing is lost or duplicated.
- Empty gating:
  - Stimulus: fifo_empty=3'b010 with data pending.
  - Required: fifo_read=000 and no state change; clearing empty resumes issue the next cycle.
- Wrap:
  - Stimulus: ACC_W=16; three entries on r7 with val=127 and x=127, then FF.
  - Required: y_row=7, y_data=16'hBD03.
- Sentinel only:
  - Stimulus: start, then a single FF entry.
  - Required: no result; done=1 three cycles after issue.
- Reset mid-stream:
  - Stimulus: assert rst=0 for one cycle with 2 results queued and 3 in flight.
  - Required: next cycle y_valid=0, fifo_read=0, state IDLE.
  - Then start plus a fresh stream produces only the new results.
